riscv_fetch_seq: RTL and testbench

- Multi-cycle sequencer for the RV32I core's program counter and instruction fetch.
- Issues instruction-memory requests through a req/ready + rvalid handshake and holds the fetched instruction for decode.
- Waits on data-memory completion, then commits exactly one PC update per instruction by driving pc_we and pc_sel to the PC register.
- Watchdogs both memory waits; on timeout it redirects the PC to the trap vector (mtvec).

---
 rtl/riscv_fetch_seq.sv | 184 ++++++++++++++++++
 tb/tb_riscv_fetch_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_seq.sv
// riscv_fetch_pkg: PC source select shared with the PC register and decoder.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4        = 2'd0,
    PC_ALU          = 2'd1,
    PC_B_TARGET     = 2'd2,
    PC_ECALL_TARGET = 2'd3
  } pc_sel_e;

endpackage : riscv_fetch_pkg

// riscv_fetch_seq: multi-cycle PC / instruction-fetch sequencer for the RV32I core.
//   clk, x_reset          clock, asynchronous active-low reset
//   halt                  level; parks the sequencer in IDLE between instructions
//   imem_req/ready/rvalid instruction fetch handshake, imem_rdata fetched word
//   inst_out, inst_valid  latched instruction and one-cycle evaluate pulse (EXEC)
//   is_* / br_flag        decoder results, valid while inst_valid is high
//   dmem_done             data access complete (MEM_WAIT)
//   pc_we, pc_sel         PC register update; decoded in the commit cycle itself so
//                         the PC register loads on the same edge the FSM leaves it
//   trap_valid/cause      one-cycle bus-timeout trap (01 imem, 10 dmem)
//   instret               retired-instruction counter, wraps
//   busy                  high in every state except IDLE
module riscv_fetch_seq
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned WORD_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic                   halt,
  output logic                   imem_req,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  output logic [WORD_LENGTH-1:0] inst_out,
  output logic                   inst_valid,
  input  logic                   is_jump,
  input  logic                   is_branch,
  input  logic                   br_flag,
  input  logic                   is_ecall,
  input  logic                   is_mem,
  input  logic                   dmem_done,
  output logic                   pc_we,
  output pc_sel_e                pc_sel,
  output logic                   trap_valid,
  output logic [1:0]             trap_cause,
  output logic [CNT_WIDTH-1:0]   instret,
  output logic                   busy
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_WAIT,
    S_TRAP
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [WD_W-1:0] wd_q;
  logic            wd_expired_c;
  logic            wd_waiting_c;
  logic            latch_inst_c;
  logic            retire_c;
  logic [1:0]      cause_c;

  // Last wait cycle before a timeout trap.
  assign wd_expired_c = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_waiting_c = (state_d == S_FETCH_WAIT) || (state_d == S_MEM_WAIT);

  // Next state plus the commit decode (pc_we/pc_sel) for the current cycle.
  always_comb begin
    state_d      = state_q;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    latch_inst_c = 1'b0;
    retire_c     = 1'b0;
    cause_c      = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          if (imem_rvalid) begin
            latch_inst_c = 1'b1;
            state_d      = S_EXEC;
          end else begin
            state_d = S_FETCH_WAIT;
          end
        end
      end
      S_FETCH_WAIT: begin
        // A response in the expiry cycle still wins over the trap.
        if (imem_rvalid) begin
          latch_inst_c = 1'b1;
          state_d      = S_EXEC;
        end else if (wd_expired_c) begin
          cause_c = 2'b01;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_ecall) begin
          pc_we  = 1'b1;
          pc_sel = PC_ECALL_TARGET;
        end else if (is_jump) begin
          pc_we  = 1'b1;
          pc_sel = PC_ALU;
        end else if (is_branch && br_flag) begin
          pc_we  = 1'b1;
          pc_sel = PC_B_TARGET;
        end else if (!is_mem) begin
          pc_we  = 1'b1;
          pc_sel = PC_PLUS4;
        end
        if (pc_we) begin
          retire_c = 1'b1;
          state_d  = halt ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_done) begin
          pc_we    = 1'b1;
          pc_sel   = PC_PLUS4;
          retire_c = 1'b1;
          state_d  = halt ? S_IDLE : S_FETCH;
        end else if (wd_expired_c) begin
          cause_c = 2'b10;
          state_d = S_TRAP;
        end
      end
      S_TRAP: begin
        pc_we   = 1'b1;
        pc_sel  = PC_ECALL_TARGET;
        state_d = halt ? S_IDLE : S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, watchdog and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state_q    <= S_IDLE;
      wd_q       <= '0;
      imem_req   <= 1'b0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      trap_valid <= 1'b0;
      trap_cause <= 2'b00;
      instret    <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      imem_req   <= (state_d == S_FETCH);
      inst_valid <= (state_d == S_EXEC);
      trap_valid <= (state_d == S_TRAP);
      trap_cause <= (state_d == S_TRAP) ? cause_c : 2'b00;
      busy       <= (state_d != S_IDLE);
      if (latch_inst_c) inst_out <= imem_rdata;
      if (retire_c) instret <= instret + CNT_WIDTH'(1);
      // Clear on entry to a wait state, count while staying there.
      if (wd_waiting_c && (state_d != state_q)) begin
        wd_q <= '0;
      end else if (wd_waiting_c) begin
        wd_q <= wd_q + WD_W'(1);
      end
    end
  end

endmodule : riscv_fetch_seq

// File: tb/tb_riscv_fetch_seq.sv
// Directed bench for riscv_fetch_seq; commits are checked against a queue of
// expected PC updates filled as each instruction is issued.
module tb_riscv_fetch_seq;
  import riscv_fetch_pkg::*;

  localparam int unsigned WL = 32;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          x_reset;
  logic          halt;
  logic          imem_req;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [WL-1:0] imem_rdata;
  logic [WL-1:0] inst_out;
  logic          inst_valid;
  logic          is_jump;
  logic          is_branch;
  logic          br_flag;
  logic          is_ecall;
  logic          is_mem;
  logic          dmem_done;
  logic          pc_we;
  pc_sel_e       pc_sel;
  logic          trap_valid;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;
  logic          busy;

  riscv_fetch_seq #(
    .WORD_LENGTH   (WL),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk        (clk),
    .x_reset    (x_reset),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .is_jump    (is_jump),
    .is_branch  (is_branch),
    .br_flag    (br_flag),
    .is_ecall   (is_ecall),
    .is_mem     (is_mem),
    .dmem_done  (dmem_done),
    .pc_we      (pc_we),
    .pc_sel     (pc_sel),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .instret    (instret),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    pc_sel_e       sel;
    logic          trap;
    logic [1:0]    cause;
    logic [CW-1:0] ir;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [CW-1:0] exp_ir = '0;
  int            errors = 0;
  int            checks = 0;
  logic          prev_we = 1'b0;
  logic          ir_pend = 1'b0;
  logic [CW-1:0] ir_want = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_commit(input pc_sel_e s, input logic trap, input logic [1:0] cause);
    exp_t e;
    if (!trap) exp_ir = exp_ir + CW'(1);
    e.sel   = s;
    e.trap  = trap;
    e.cause = cause;
    e.ir    = exp_ir;
    sb.push_back(e);
  endtask

  // k = 0: rvalid with ready; k > 0: rvalid in FETCH_WAIT cycle k; k < 0: never.
  task automatic fetch(input logic [WL-1:0] data, input int k);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("imem_req_wait", 64'(imem_req), 64'(1));
    imem_ready = 1'b1;
    if (k == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data;
    end
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    if (k > 0) begin
      repeat (k - 1) step();
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
    end else if (k < 0) begin
      repeat (TO) step();
    end
  endtask

  // Non-memory instruction: flags = {ecall, jump, branch, br_flag, mem}.
  task automatic run_op(input string tag, input logic [WL-1:0] data, input logic [4:0] flags,
                        input pc_sel_e want, input int k);
    {is_ecall, is_jump, is_branch, br_flag, is_mem} = flags;
    push_commit(want, 1'b0, 2'b00);
    fetch(data, k);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'(1));
    chk({tag, "_inst_out"}, 64'(inst_out), 64'(data));
    step();
    {is_ecall, is_jump, is_branch, br_flag, is_mem} = 5'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_imem_req"}, 64'(imem_req), 64'(0));
    chk({tag, "_inst_out"}, 64'(inst_out), 64'(0));
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'(0));
    chk({tag, "_pc_we"}, 64'(pc_we), 64'(0));
    chk({tag, "_pc_sel"}, 64'(pc_sel), 64'(PC_PLUS4));
    chk({tag, "_trap_valid"}, 64'(trap_valid), 64'(0));
    chk({tag, "_trap_cause"}, 64'(trap_cause), 64'(0));
    chk({tag, "_instret"}, 64'(instret), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Commit monitor: every pc_we must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!x_reset) begin
      prev_we = 1'b0;
      ir_pend = 1'b0;
    end else begin
      if (ir_pend) begin
        chk("instret", 64'(instret), 64'(ir_want));
        ir_pend = 1'b0;
      end
      if (pc_we) begin
        chk("pc_we_back_to_back", 64'(prev_we), 64'(0));
        if (sb.size() == 0) begin
          chk("unexpected_pc_we", 64'(pc_we), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          chk("pc_sel", 64'(pc_sel), 64'(mon_e.sel));
          chk("trap_valid", 64'(trap_valid), 64'(mon_e.trap));
          chk("trap_cause", 64'(trap_cause), 64'(mon_e.cause));
          ir_pend = 1'b1;
          ir_want = mon_e.ir;
        end
      end else begin
        chk("idle_pc_sel", 64'(pc_sel), 64'(PC_PLUS4));
        chk("stray_trap", 64'(trap_valid), 64'(0));
      end
      prev_we = pc_we;
    end
  end

  initial begin
    x_reset     = 1'b0;
    halt        = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    is_jump     = 1'b0;
    is_branch   = 1'b0;
    br_flag     = 1'b0;
    is_ecall    = 1'b0;
    is_mem      = 1'b0;
    dmem_done   = 1'b0;
    repeat (2) step();
    chk_reset_vals("reset");

    // First fetch after reset: ready, then rvalid one cycle later.
    x_reset = 1'b1;
    run_op("addi", 32'h0000_0013, 5'b00000, PC_PLUS4, 1);
    chk("after_exec_imem_req", 64'(imem_req), 64'(1));
    chk("after_exec_inst_valid", 64'(inst_valid), 64'(0));

    // Control flow and priority.
    run_op("jal", 32'h0080_00EF, 5'b01000, PC_ALU, 0);
    run_op("beq_taken", 32'h0000_0463, 5'b00110, PC_B_TARGET, 2);
    run_op("beq_not", 32'h0000_0463, 5'b00100, PC_PLUS4, 0);
    run_op("ecall_jump", 32'h0000_0073, 5'b11000, PC_ECALL_TARGET, 3);

    // Load: dmem_done in the 5th MEM_WAIT cycle.
    is_mem = 1'b1;
    fetch(32'h0000_2003, 0);
    chk("load_inst_valid", 64'(inst_valid), 64'(1));
    step();
    is_mem = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    repeat (4) step();
    push_commit(PC_PLUS4, 1'b0, 2'b00);
    dmem_done = 1'b1;
    step();
    dmem_done = 1'b0;

    // imem never answers: trap after TO FETCH_WAIT cycles.
    push_commit(PC_ECALL_TARGET, 1'b1, 2'b01);
    fetch(32'h0000_0013, -1);
    chk("itrap_valid_reg", 64'(trap_valid), 64'(1));
    chk("itrap_cause_reg", 64'(trap_cause), 64'(2'b01));
    chk("itrap_inst_valid", 64'(inst_valid), 64'(0));
    step();

    // rvalid in the last watchdog cycle wins.
    run_op("late_rvalid", 32'h0010_0093, 5'b00000, PC_PLUS4, TO);

    // dmem never completes: trap with cause 10.
    is_mem = 1'b1;
    fetch(32'h0000_2023, 0);
    step();
    is_mem = 1'b0;
    push_commit(PC_ECALL_TARGET, 1'b1, 2'b10);
    repeat (TO) step();
    chk("dtrap_cause_reg", 64'(trap_cause), 64'(2'b10));
    step();

    // Halt during MEM_WAIT: finish, commit, park in IDLE.
    is_mem = 1'b1;
    fetch(32'h0000_2003, 0);
    step();
    is_mem = 1'b0;
    halt   = 1'b1;
    repeat (2) step();
    push_commit(PC_PLUS4, 1'b0, 2'b00);
    dmem_done = 1'b1;
    step();
    dmem_done = 1'b0;
    chk("halt_busy", 64'(busy), 64'(0));
    chk("halt_imem_req", 64'(imem_req), 64'(0));
    dmem_done = 1'b1;
    repeat (2) step();
    dmem_done = 1'b0;
    chk("halt_parked_busy", 64'(busy), 64'(0));
    halt = 1'b0;
    step();
    chk("unhalt_imem_req", 64'(imem_req), 64'(1));
    chk("unhalt_busy", 64'(busy), 64'(1));

    // Reset in FETCH_WAIT; a late rvalid after release is ignored.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    halt    = 1'b1;
    x_reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    exp_ir = '0;
    step();
    x_reset     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    repeat (2) step();
    imem_rvalid = 1'b0;
    chk("late_rvalid_inst_valid", 64'(inst_valid), 64'(0));
    chk("late_rvalid_inst_out", 64'(inst_out), 64'(0));
    chk("late_rvalid_busy", 64'(busy), 64'(0));
    halt = 1'b0;

    // instret wraps after 2^CW retirements.
    for (int i = 0; i < (1 << CW); i++) begin
      run_op("wrap", 32'h0000_0013, 5'b00000, PC_PLUS4, 0);
    end
    chk("instret_wrap", 64'(instret), 64'(0));

    halt = 1'b1;
    repeat (4) step();
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_riscv_fetch_seq
